// File: rtl/pitch_shifter_pkg.sv
// Shared definitions for the pitch-shifter streaming path: hop size,
// saturating signed add and the overlap-add sequencing states.
package pitch_shifter_pkg;

  // Overlap-add sequencing: PRIME ignores stale tail memory for the first frame.
  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } oa_state_e;

  localparam int DEFAULT_ADDRWIDTH = 12;

  // Hop is half a window.
  function automatic int hop_of(input int addrwidth);
    return 1 << (addrwidth - 1);
  endfunction

  localparam int HOP = hop_of(DEFAULT_ADDRWIDTH);

  // Signed add of two sign-extended operands, clamped to a w-bit range.
  // Operands must already fit in w bits; w must be at most 31.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      return hi[31:0];
    end else if (s < lo) begin
      return lo[31:0];
    end else begin
      return s[31:0];
    end
  endfunction

endpackage

// File: rtl/overlap_add_manager_tail_ram.sv
// Tail storage for overlap-add: one write port, one registered read port.
// Storage is deliberately not reset; the PRIME frame masks stale contents.
module tail_ram #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port and 1-cycle registered read port; read data holds when re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/overlap_add_manager.sv
// Overlap-add of windowed synthesis frames at a hop of N/2. The head half of
// each frame is summed with the previous frame's stored tail and streamed out;
// the tail half is stored for the next frame.
module overlap_add_manager
  import pitch_shifter_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 framing_error
);

  localparam int HW = ADDRWIDTH - 1;
  localparam int HOP_LEN = hop_of(ADDRWIDTH);
  localparam logic [ADDRWIDTH-1:0] IDX_LAST  = '1;
  localparam logic [HW-1:0]        HEAD_LAST = HW'(HOP_LEN - 1);

  // Frame position and sequencing
  logic [ADDRWIDTH-1:0] win_idx_q, win_idx_d;
  oa_state_e            state_q, state_d;
  logic                 ferr_q, ferr_d;

  // Stage A: accepted sample waiting for its RAM read data (head) or write (tail)
  logic                        a_valid_q, a_valid_d;
  logic                        a_head_q, a_head_d;
  logic                        a_prime_q, a_prime_d;
  logic [HW-1:0]               a_idx_q, a_idx_d;
  logic signed [DATAWIDTH-1:0] a_data_q, a_data_d;

  // Stage B holding register: keeps RAM read data while the output is blocked
  logic                        hold_valid_q, hold_valid_d;
  logic signed [DATAWIDTH-1:0] hold_data_q, hold_data_d;

  // Output register
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [DATAWIDTH-1:0]        out_data_q, out_data_d;

  logic                        accept;
  logic                        out_free;
  logic                        head_stall;
  logic                        out_load;
  logic                        in_is_head;
  logic signed [DATAWIDTH-1:0] addend;
  logic [DATAWIDTH-1:0]        ram_rdata;

  // Handshake decode; in_ready depends on registered state and out_ready only.
  always_comb begin
    out_free   = !out_valid_q || out_ready;
    head_stall = a_valid_q && a_head_q && !out_free;
    in_ready   = !head_stall;
    accept     = in_valid && in_ready;
    in_is_head = !win_idx_q[ADDRWIDTH-1];
    out_load   = a_valid_q && a_head_q && out_free;
  end

  // Tail memory: head samples read at accept, tail samples write from stage A.
  tail_ram #(
    .AW (HW),
    .DW (DATAWIDTH)
  ) u_tail_ram (
    .clk   (clock),
    .we    (a_valid_q && !a_head_q),
    .waddr (a_idx_q),
    .wdata (a_data_q),
    .re    (accept && in_is_head),
    .raddr (win_idx_q[HW-1:0]),
    .rdata (ram_rdata)
  );

  // Window index, PRIME/RUN sequencing and sticky framing check.
  always_comb begin
    win_idx_d = win_idx_q;
    state_d   = state_q;
    ferr_d    = ferr_q;
    if (accept) begin
      win_idx_d = win_idx_q + 1'b1;
      if (win_idx_q == IDX_LAST) begin
        state_d = ST_RUN;
      end
      if (in_last != (win_idx_q == IDX_LAST)) begin
        ferr_d = 1'b1;
      end
    end
  end

  // Stage A advance/load; a stalled head is the only thing that holds it.
  always_comb begin
    a_valid_d = a_valid_q;
    a_head_d  = a_head_q;
    a_prime_d = a_prime_q;
    a_idx_d   = a_idx_q;
    a_data_d  = a_data_q;
    if (a_valid_q && !head_stall) begin
      a_valid_d = 1'b0;
    end
    if (accept) begin
      a_valid_d = 1'b1;
      a_head_d  = in_is_head;
      a_prime_d = (state_q == ST_PRIME);
      a_idx_d   = win_idx_q[HW-1:0];
      a_data_d  = $signed(in_data);
    end
  end

  // Capture RAM data on the first stalled cycle so later reads cannot disturb it.
  always_comb begin
    hold_valid_d = head_stall;
    hold_data_d  = hold_data_q;
    if (head_stall && !hold_valid_q) begin
      hold_data_d = $signed(ram_rdata);
    end
  end

  // Stage B: overlap-add with saturation into the output register.
  always_comb begin
    if (a_prime_q) begin
      addend = '0;
    end else if (hold_valid_q) begin
      addend = hold_data_q;
    end else begin
      addend = $signed(ram_rdata);
    end
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (out_load) begin
      out_valid_d = 1'b1;
      out_last_d  = (a_idx_q == HEAD_LAST);
      out_data_d  = DATAWIDTH'(sat_add(32'(addend), 32'(a_data_q), DATAWIDTH));
    end
  end

  // All control and pipeline state; reset discards any partial frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_idx_q    <= '0;
      state_q      <= ST_PRIME;
      ferr_q       <= 1'b0;
      a_valid_q    <= 1'b0;
      a_head_q     <= 1'b0;
      a_prime_q    <= 1'b0;
      a_idx_q      <= '0;
      a_data_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      win_idx_q    <= win_idx_d;
      state_q      <= state_d;
      ferr_q       <= ferr_d;
      a_valid_q    <= a_valid_d;
      a_head_q     <= a_head_d;
      a_prime_q    <= a_prime_d;
      a_idx_q      <= a_idx_d;
      a_data_q     <= a_data_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_data      = out_data_q;
  assign framing_error = ferr_q;

endmodule

// File: tb/tb_overlap_add_manager.sv
// Scoreboard bench for overlap_add_manager with N=16, HOP=8.
module tb_overlap_add_manager;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        framing_error;

  overlap_add_manager #(.ADDRWIDTH(4), .DATAWIDTH(16)) dut (
    .clock         (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rand_ready = 0;
  bit   gaps = 0;

  // Reference model state: position in frame, prime flag, stored tail, framing flag
  int   m_idx = 0;
  bit   m_prime = 1;
  int   m_tail[8];
  bit   m_ferr = 0;
  int   first_acc_cyc = -1;
  int   first_out_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream readiness
  always @(negedge clk) out_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  function automatic int sat16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic model_accept(input logic [15:0] d, input bit last);
    int dv;
    exp_t e;
    dv = int'($signed(d));
    if (first_acc_cyc < 0) first_acc_cyc = cyc;
    if (last != (m_idx == 15)) m_ferr = 1;
    if (m_idx < 8) begin
      e.d = 16'(sat16((m_prime ? 0 : m_tail[m_idx]) + dv));
      e.last = (m_idx == 7);
      exp_q.push_back(e);
    end else begin
      m_tail[m_idx - 8] = dv;
    end
    if (m_idx == 15) begin
      m_idx = 0;
      m_prime = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic send(input logic [15:0] d, input bit last);
    int guard;
    bit done;
    guard = 0;
    done = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = d;
      in_last = last;
      #4;
      if (in_ready) begin
        model_accept(d, last);
        done = 1;
      end else begin
        guard++;
        if (guard > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: in_ready stuck at %0b, required 1 within 200 cycles", in_ready);
          done = 1;
        end
      end
    end
  endtask

  // mode 0: constant head/tail, 1: ramp, 2: random; bad_idx puts in_last early
  task automatic send_frame(input int mode, input int head_v, input int tail_v, input int bad_idx);
    logic [15:0] d;
    bit last;
    for (int i = 0; i < 16; i++) begin
      if (mode == 0) d = 16'((i < 8) ? head_v : tail_v);
      else if (mode == 1) d = 16'(i);
      else d = 16'($urandom);
      last = (i == 15) || (i == bad_idx);
      send(d, last);
    end
  endtask

  task automatic idle_and_drain();
    int guard;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks protocol rules
  initial begin
    bit          prev_stall;
    logic [15:0] prev_d;
    logic        prev_l;
    exp_t        e;
    prev_stall = 0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset_n) begin
        prev_stall = 0;
        continue;
      end
      checks++;
      if (framing_error !== m_ferr) begin
        errors++;
        $display("FAIL framing_error: got %0b, required %0b (cycle %0d)", framing_error, m_ferr, cyc);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b d=%0d l=%0b, required v=1 d=%0d l=%0b",
                   out_valid, out_data, out_last, prev_d, prev_l);
        end
      end
      if (!in_ready) begin
        checks++;
        if (!(out_valid && !out_ready)) begin
          errors++;
          $display("FAIL in_ready_rule: in_ready=0 with out_valid=%0b out_ready=%0b, required stalled output",
                   out_valid, out_ready);
        end
      end
      if (out_valid && out_ready) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got d=%0d l=%0b, required no output", $signed(out_data), out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_last !== e.last) begin
            errors++;
            $display("FAIL out_sample: got d=%0d l=%0b, required d=%0d l=%0b",
                     $signed(out_data), out_last, $signed(e.d), e.last);
          end else begin
            $display("out d=%0d last=%0b cycle=%0d", $signed(out_data), out_last, cyc);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_tail[i] = 0;
    // Reset state
    #12;
    checks++;
    if (out_valid !== 1'b0 || framing_error !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%0b ferr=%0b rdy=%0b, required 0 0 1", out_valid, framing_error, in_ready);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;

    // 1: PRIME frame of 100s, latency check
    send_frame(0, 100, 100, -1);
    idle_and_drain();
    checks++;
    if (first_out_cyc - first_acc_cyc != 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required 2", first_out_cyc - first_acc_cyc);
    end

    // 2: steady overlap-add, then 3: saturation chain
    send_frame(0, 100, 100, -1);
    send_frame(0, 5, 30000, -1);
    send_frame(0, 30000, -30000, -1);
    send_frame(0, -30000, -1, -1);
    send_frame(0, 1, 0, -1);
    idle_and_drain();

    // 4: ramps and random data under random backpressure and input gaps
    rand_ready = 1;
    gaps = 1;
    for (int f = 0; f < 3; f++) send_frame(1, 0, 0, -1);
    for (int f = 0; f < 4; f++) send_frame(2, 0, 0, -1);
    idle_and_drain();
    rand_ready = 0;
    gaps = 0;

    // 5: early in_last sets sticky framing_error; data path unaffected
    checks++;
    if (framing_error !== 1'b0) begin
      errors++;
      $display("FAIL ferr_before: got %0b, required 0", framing_error);
    end
    send_frame(1, 0, 0, 5);
    send_frame(0, 3, 4, -1);
    idle_and_drain();
    checks++;
    if (framing_error !== 1'b1) begin
      errors++;
      $display("FAIL ferr_sticky: got %0b, required 1", framing_error);
    end

    // 6: asynchronous reset in the head phase, then a PRIME frame of 7s
    for (int i = 0; i < 4; i++) send(16'd50, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || framing_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%0b ferr=%0b, required 0 0", out_valid, framing_error);
    end
    exp_q.delete();
    m_idx = 0;
    m_prime = 1;
    m_ferr = 0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    send_frame(0, 7, 7, -1);
    idle_and_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
